// File: rtl/alien_grid_drawer_pkg.sv
// alien_pkg: shared types and constants for the alien grid drawer.
// FSM state and pass encodings, coordinate/color widths, default colors
// and the screen size the group is expected to stay within.
package alien_pkg;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 4;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [COLOR_W-1:0] BG_COLOR_DEF    = 4'd0;
  localparam logic [COLOR_W-1:0] ENEMY_COLOR_DEF = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } grid_state_t;

  typedef enum logic {
    P_ERASE,
    P_DRAW
  } pass_t;

  // One sprite job as presented to the sprite drawer.
  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } job_t;

endpackage

// File: rtl/alien_grid_drawer_if.sv
// Frame request / sprite job bus between game logic, the grid drawer and
// the single-sprite pixel writer. slave = the grid drawer's view.
interface alien_grid_drawer_if
  import alien_pkg::*;
#(
  parameter int NUM_ALIENS = 20
);
  localparam int IW = $clog2(NUM_ALIENS);

  // frame request side
  logic                  start;
  logic [X_W-1:0]        group_x;
  logic [Y_W-1:0]        group_y;
  logic [NUM_ALIENS-1:0] alive_mask;
  logic                  busy;
  logic                  done;

  // sprite job side
  logic                  sprite_start;
  logic                  sprite_done;
  logic [X_W-1:0]        center_x;
  logic [Y_W-1:0]        center_y;
  logic [COLOR_W-1:0]    color;
  logic [IW-1:0]         which_alien;

  modport slave (
    input  start, group_x, group_y, alive_mask, sprite_done,
    output busy, done, sprite_start, center_x, center_y, color, which_alien
  );

  modport master (
    output start, group_x, group_y, alive_mask, sprite_done,
    input  busy, done, sprite_start, center_x, center_y, color, which_alien
  );

endinterface

// File: rtl/alien_grid_drawer_center_calc.sv
// alien_center_calc: combinational sprite center for alien idx_i of a
// group centered at (gx_i, gy_i). Signed integer math, truncated to the
// coordinate widths with no clamping.
module alien_center_calc
  import alien_pkg::*;
#(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_COLS     = 5,
  parameter int ALIEN_WIDTH  = 40,
  parameter int ALIEN_HEIGHT = 21,
  parameter int ALIEN_GAP    = 21,
  parameter int IW           = 5
) (
  input  logic [IW-1:0]  idx_i,
  input  logic [X_W-1:0] gx_i,
  input  logic [Y_W-1:0] gy_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o
);

  localparam int PITCH_X = ALIEN_WIDTH + ALIEN_GAP;
  localparam int PITCH_Y = ALIEN_HEIGHT + ALIEN_GAP;
  // Middle column sits on the group center; rows are centered vertically.
  localparam int HALF_C  = (NUM_COLS - 1) / 2;
  localparam int Y_OFF   = ((NUM_ROWS - 1) * PITCH_Y) / 2;

  int row;
  int col;

  // Index -> (row, col) -> pixel center.
  always_comb begin
    row = int'(idx_i) / NUM_COLS;
    col = int'(idx_i) % NUM_COLS;
    x_o = X_W'(int'(gx_i) + (col - HALF_C) * PITCH_X);
    y_o = Y_W'(int'(gy_i) - Y_OFF + row * PITCH_Y);
  end

endmodule

// File: rtl/alien_grid_drawer.sv
// alien_grid_drawer: per-frame erase/redraw sequencer for an alien grid.
// On start it diffs the new position/alive mask against the last drawn
// frame and issues only the sprite jobs needed: full erase+redraw on a
// move, erase-only for aliens killed in place.
// Optional feature macro: ALIEN_ROW_COLOR_EN -- draw color becomes
// ROW_COLOR_BASE + row (4-bit wrap) instead of ENEMY_COLOR.
module alien_grid_drawer
  import alien_pkg::*;
#(
  parameter int                 NUM_ROWS       = 4,
  parameter int                 NUM_COLS       = 5,
  parameter int                 ALIEN_WIDTH    = 40,
  parameter int                 ALIEN_HEIGHT   = 21,
  parameter int                 ALIEN_GAP      = 21,
  parameter int                 START_X        = 320,
  parameter int                 START_Y        = 105,
  parameter logic [COLOR_W-1:0] BG_COLOR       = BG_COLOR_DEF,
  parameter logic [COLOR_W-1:0] ENEMY_COLOR    = ENEMY_COLOR_DEF,
  parameter logic [COLOR_W-1:0] ROW_COLOR_BASE = 4'd3
) (
  input  logic                clock,
  input  logic                reset_n,
  alien_grid_drawer_if.slave  bus
);

  localparam int NA = NUM_ROWS * NUM_COLS;
  localparam int IW = $clog2(NA);
  localparam logic [IW-1:0] LAST_IDX = IW'(NA - 1);

  grid_state_t     state_q;
  pass_t           pass_q;
  logic [IW-1:0]   idx_q;
  logic [X_W-1:0]  lat_x_q, prev_x_q;
  logic [Y_W-1:0]  lat_y_q, prev_y_q;
  logic [NA-1:0]   lat_mask_q, prev_mask_q;
  logic [NA-1:0]   erase_set_q, draw_set_q;
  logic            drawn_q;
  job_t            job_q;
  logic [IW-1:0]   which_q;
  logic            sprite_start_q, busy_q, done_q;

  logic            moved;
  logic [NA-1:0]   erase_set_d, draw_set_d;
  logic            in_set;
  grid_state_t     adv_state_d;
  pass_t           adv_pass_d;
  logic [IW-1:0]   adv_idx_d;
  logic [X_W-1:0]  calc_gx, calc_x;
  logic [Y_W-1:0]  calc_gy, calc_y;
  logic [COLOR_W-1:0] job_color;

  // Work selection from the incoming request vs. the last drawn frame.
  always_comb begin
    moved       = (bus.group_x != prev_x_q) || (bus.group_y != prev_y_q) || !drawn_q;
    erase_set_d = '0;
    if (drawn_q)
      erase_set_d = moved ? prev_mask_q : (prev_mask_q & ~bus.alive_mask);
    draw_set_d  = moved ? bus.alive_mask : '0;
  end

  // Step to the next index, rolling into the draw pass or finishing.
  always_comb begin
    adv_state_d = S_SCAN;
    adv_pass_d  = pass_q;
    adv_idx_d   = idx_q + 1'b1;
    if (idx_q == LAST_IDX) begin
      adv_idx_d = '0;
      if (pass_q == P_ERASE) adv_pass_d  = P_DRAW;
      else                   adv_state_d = S_FINISH;
    end
  end

  // Erase jobs use the old position, draw jobs the latched new one.
  always_comb begin
    in_set  = (pass_q == P_ERASE) ? erase_set_q[idx_q] : draw_set_q[idx_q];
    calc_gx = (pass_q == P_ERASE) ? prev_x_q : lat_x_q;
    calc_gy = (pass_q == P_ERASE) ? prev_y_q : lat_y_q;
`ifdef ALIEN_ROW_COLOR_EN
    job_color = (pass_q == P_ERASE) ? BG_COLOR
              : COLOR_W'(int'(ROW_COLOR_BASE) + int'(idx_q) / NUM_COLS);
`else
    job_color = (pass_q == P_ERASE) ? BG_COLOR : ENEMY_COLOR;
`endif
  end

  alien_center_calc #(
    .NUM_ROWS     (NUM_ROWS),
    .NUM_COLS     (NUM_COLS),
    .ALIEN_WIDTH  (ALIEN_WIDTH),
    .ALIEN_HEIGHT (ALIEN_HEIGHT),
    .ALIEN_GAP    (ALIEN_GAP),
    .IW           (IW)
  ) u_calc (
    .idx_i (idx_q),
    .gx_i  (calc_gx),
    .gy_i  (calc_gy),
    .x_o   (calc_x),
    .y_o   (calc_y)
  );

  // Frame sequencer with registered job/status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      pass_q         <= P_ERASE;
      idx_q          <= '0;
      lat_x_q        <= X_W'(START_X);
      lat_y_q        <= Y_W'(START_Y);
      lat_mask_q     <= '1;
      prev_x_q       <= X_W'(START_X);
      prev_y_q       <= Y_W'(START_Y);
      prev_mask_q    <= '1;
      drawn_q        <= 1'b0;
      erase_set_q    <= '0;
      draw_set_q     <= '0;
      job_q          <= '{x: '0, y: '0, color: BG_COLOR};
      which_q        <= '0;
      sprite_start_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            lat_x_q     <= bus.group_x;
            lat_y_q     <= bus.group_y;
            lat_mask_q  <= bus.alive_mask;
            erase_set_q <= erase_set_d;
            draw_set_q  <= draw_set_d;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            if (erase_set_d == '0 && draw_set_d == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SCAN;
              pass_q  <= (erase_set_d != '0) ? P_ERASE : P_DRAW;
            end
          end
        end
        S_SCAN: begin
          if (in_set) begin
            state_q        <= S_ISSUE;
            job_q          <= '{x: calc_x, y: calc_y, color: job_color};
            which_q        <= idx_q;
            sprite_start_q <= 1'b1;
          end else begin
            state_q <= adv_state_d;
            pass_q  <= adv_pass_d;
            idx_q   <= adv_idx_d;
            if (adv_state_d == S_FINISH) done_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          sprite_start_q <= 1'b0;
          state_q        <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.sprite_done) begin
            state_q <= adv_state_d;
            pass_q  <= adv_pass_d;
            idx_q   <= adv_idx_d;
            if (adv_state_d == S_FINISH) done_q <= 1'b1;
          end
        end
        S_FINISH: begin
          prev_x_q    <= lat_x_q;
          prev_y_q    <= lat_y_q;
          prev_mask_q <= lat_mask_q;
          drawn_q     <= 1'b1;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sprite_start = sprite_start_q;
  assign bus.center_x     = job_q.x;
  assign bus.center_y     = job_q.y;
  assign bus.color        = job_q.color;
  assign bus.which_alien  = which_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: doc/alien_grid_drawer.md
# alien_grid_drawer

Parametrised successor to the fixed 4×5 alien group drawer. On each `start` request it compares the new group position and alive mask against the last frame it drew. It then sequences per-alien sprite erase and draw jobs to the downstream sprite drawer through a start/done handshake. Only the aliens that need it are touched: full erase and redraw on a move, erase-only for aliens killed in place. It sits between game-logic position/alive state and the single-sprite pixel writer.

## Interface
- `NUM_ROWS`, 4, alien rows
- `NUM_COLS`, 5, alien columns; `NUM_ALIENS = NUM_ROWS*NUM_COLS`, max 32
- `ALIEN_WIDTH`, 40, sprite width in px
- `ALIEN_HEIGHT`, 21, sprite height in px
- `ALIEN_GAP`, 21, spacing between sprites in px
- `START_X`, 320, group center x after reset
- `START_Y`, 105, group center y after reset
- `BG_COLOR`, 0, erase color index
- `ENEMY_COLOR`, 3, draw color index
- `ROW_COLOR_BASE`, 3, first row's color (see Configuration)
- `clock` in 1: single clock, all logic on the rising edge
- `reset_n` in 1: synchronous, active-low
- `start` in 1: frame-update request, one-cycle pulse, sampled only in IDLE
- `group_x` in 10, `group_y` in 9: new group center, latched on accepted `start`
- `alive_mask` in NUM_ALIENS: bit i set = alien i alive; latched on accepted `start`
- `sprite_done` in 1: one-cycle pulse from the sprite drawer, honoured only in WAIT
- `sprite_start` out 1: one-cycle job pulse
- `center_x` out 10, `center_y` out 9: job sprite center
- `color` out 4: job color
- `which_alien` out $clog2(NUM_ALIENS): job index
- `busy` out 1: high whenever not IDLE
- `done` out 1: one-cycle pulse at frame completion

## Operation
- Alien index i: row = i / NUM_COLS, col = i % NUM_COLS.
- PITCH_X = W+GAP; PITCH_Y = H+GAP.
- x = gx + (col − (NUM_COLS−1)/2)·PITCH_X.
- y = gy − ((NUM_ROWS−1)·PITCH_Y)/2 + row·PITCH_Y.
- Arithmetic is signed with integer-truncating divides; results are truncated to 10/9 bits with no clamping. The caller keeps the group on screen.
- State kept between frames: `prev_x`, `prev_y`, `prev_mask`, `drawn`.
- Work selection on accepted `start`:
  - `moved` = (new x,y ≠ prev x,y) or !`drawn`.
  - Erase set: if `drawn`=0, empty; if moved, `prev_mask` at prev position; otherwise `prev_mask & ~alive_mask` at prev position.
  - Draw set: if moved, the new `alive_mask` at the new position; otherwise empty.
- States:
  - IDLE: on `start`, latch inputs. If both sets are empty, go to FINISH; otherwise go to SCAN with pass=ERASE (or DRAW if the erase set is empty) and idx=0.
  - SCAN: if idx is in the current pass set, go to ISSUE. Otherwise advance: idx+1, or at idx=NUM_ALIENS−1 move to the next pass, or to FINISH after DRAW.
  - ISSUE: drive center/color/which_alien, pulse `sprite_start`, go to WAIT.
  - WAIT: hold outputs; on `sprite_done`, advance exactly as in SCAN.
  - FINISH: `done`=1 for one cycle. Set prev_x/y ← latched position, prev_mask ← latched mask, `drawn` ← 1. Go to IDLE.
- `color` is BG_COLOR in the ERASE pass and the draw color in the DRAW pass.
- Boundaries:
  - `start` while busy: ignored.
  - `sprite_done` outside WAIT: ignored.
  - `sprite_done` coincident with `sprite_start`: not possible, since WAIT begins the cycle after ISSUE.
  - `alive_mask` changing mid-frame: no effect, because the latched copy is used.

## Timing
- Reset (reset_n=0 at an edge) from any state, including mid-WAIT:
  - next cycle is IDLE; `sprite_start`, `done`, `busy` = 0.
  - `center_x`, `center_y`, `which_alien` = 0; `color` = BG_COLOR.
  - prev_x/y = START_X/Y; prev_mask = all ones; `drawn` = 0.
- `start` accepted at edge k:
  - `busy` is high from cycle k+1.
  - No-work frame: `done` is high in cycle k+1.
- Costs: an unselected index costs 1 cycle; a selected index costs SCAN + ISSUE + wait cycles.
- Job outputs are valid from the ISSUE cycle until WAIT exits.
- `done` and `busy` fall together on return to IDLE.

## Configuration
- `ALIEN_ROW_COLOR_EN` defined: draw color = ROW_COLOR_BASE + row, 4-bit wrap.
- Undefined: all rows are drawn in ENEMY_COLOR.
- Erase color is BG_COLOR in both cases.

## Structure
- Package `alien_pkg`:
  - state enum typedef `grid_state_t`
  - pass enum `pass_t`
  - BG/ENEMY color constants
  - screen width constants
- Sub-module `alien_center_calc`: combinational index+group → (x,y), parametrised by rows/cols/size/gap. One instance, muxed between prev and new position by pass.

## Test plan
Defaults throughout. The bench model answers each `sprite_start` with `sprite_done` 3 cycles later.
- Reset, then start (320,105) with all ones → 20 draw jobs. First job (198,42) ENEMY_COLOR; alien 19 at (442,168). One `done`.
- Same position, bit 7 cleared → exactly one job: alien 7 at (320,84), color 0. Then `done`.
- Move to (330,105) with bit 7 still clear → 19 erases at the old position, then 19 draws. Alien 8 draws at (391,84); no job for index 7.
- Repeat the identical start → `done` in cycle k+1, zero `sprite_start` pulses.
- reset_n low during WAIT → `busy`=0 next cycle. The following start produces a draw-only pass with 20 jobs and no erases.
- `start` pulsed mid-frame and `sprite_done` pulsed in IDLE → no change in job count or sequence.
